// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Package   : jam_pkg
// Purpose   : Shared types and elaboration-time helpers for the exhaustive
//             assignment solver (jam_solver) and its bus interface.
// Contents  : state_e  - solver FSM states
//             perm_t   - permutation vector sized for the largest legal N
//             fact()   - n!
//             cnt_w()  - bits needed to hold 0..n! (MatchCount width)
// Revision  : 1.0 - initial release
// ============================================================================
package jam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int c_N_MAX  = 8;
  localparam int c_IW_MAX = 3;

  // Element k holds the job assigned to worker k.
  typedef logic [c_N_MAX-1:0][c_IW_MAX-1:0] perm_t;

  function automatic int unsigned fact(input int unsigned n);
    int unsigned f;
    f = 1;
    for (int unsigned k = 2; k <= n; k++) begin
      f = f * k;
    end
    return f;
  endfunction

  // Width of a counter that must reach n! without wrapping.
  function automatic int cnt_w(input int unsigned n);
    return $clog2(fact(n) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jam_solver_if.sv
`default_nettype none
// ============================================================================
// Interface : jam_solver_if
// Purpose   : Control/result and cost-table read bus of jam_solver.
// Signals   : START      harness -> solver  begin a solve
//             W, J       solver -> harness  worker/job address of cost read
//             Cost       harness -> solver  cost[W][J], one cycle after W/J
//             BUSY       solver -> harness  LOAD or CALC in progress
//             Valid      solver -> harness  result valid
//             MinCost    solver -> harness  minimum total cost
//             MatchCount solver -> harness  assignments reaching MinCost
//             BestPerm   solver -> harness  only with JAM_BEST_PERM_EN
// Modports  : master (harness side), slave (solver side)
// Macro     : JAM_BEST_PERM_EN adds BestPerm
// Revision  : 1.0 - initial release
// ============================================================================
interface jam_solver_if
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 7
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);
  localparam int MW = cnt_w(N);

  logic          START;
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;
  logic          BUSY;
  logic          Valid;
  logic [SW-1:0] MinCost;
  logic [MW-1:0] MatchCount;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] BestPerm;

  modport master (
    output START, Cost,
    input  W, J, BUSY, Valid, MinCost, MatchCount, BestPerm
  );
  modport slave (
    input  START, Cost,
    output W, J, BUSY, Valid, MinCost, MatchCount, BestPerm
  );
`else
  modport master (
    output START, Cost,
    input  W, J, BUSY, Valid, MinCost, MatchCount
  );
  modport slave (
    input  START, Cost,
    output W, J, BUSY, Valid, MinCost, MatchCount
  );
`endif

endinterface
`default_nettype wire

// File: rtl/jam_next_perm.sv
`default_nettype none
// ============================================================================
// Module    : jam_next_perm
// Purpose   : Combinational successor of a permutation in lexicographic
//             order (element 0 most significant).
// Ports     : i_order       current permutation, element k at [k]
//             o_next_order  next permutation (don't-care when o_is_last)
//             o_is_last     i_order is descending, no successor exists
// Revision  : 1.0 - initial release
// ============================================================================
module jam_next_perm #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0][IW-1:0] i_order,
  output logic [N-1:0][IW-1:0] o_next_order,
  output logic                 o_is_last
);

  logic [IW-1:0] w_pivot;  // rightmost k with order[k] < order[k+1]
  logic [IW-1:0] w_succ;   // rightmost element greater than the pivot

  always_comb begin
    o_is_last = 1'b1;
    w_pivot   = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (i_order[k] < i_order[k+1]) begin
        o_is_last = 1'b0;
        w_pivot   = IW'(k);
      end
    end
  end

  always_comb begin
    w_succ = '0;
    for (int k = 0; k < N; k++) begin
      if ((IW'(k) > w_pivot) && (i_order[k] > i_order[w_pivot])) begin
        w_succ = IW'(k);
      end
    end
  end

  // Swap pivot with its successor, then reverse the suffix. The suffix
  // reversal maps position k to source N + pivot - k; the swapped-in pivot
  // value sits wherever the successor used to be.
  always_comb begin
    o_next_order = i_order;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == w_pivot) begin
        o_next_order[k] = i_order[w_succ];
      end else if (IW'(k) > w_pivot) begin
        if (IW'(N + int'(w_pivot) - k) == w_succ) begin
          o_next_order[k] = i_order[w_pivot];
        end else begin
          o_next_order[k] = i_order[IW'(N + int'(w_pivot) - k)];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jam_solver.sv
`default_nettype none
// ============================================================================
// Module    : jam_solver
// Purpose   : Exhaustive N-worker/N-job assignment solver. Loads an NxN cost
//             table over the W/J/Cost read port, evaluates all N!
//             permutations (one per cycle, lexicographic order) and reports
//             the minimum total cost and how many assignments achieve it.
// Ports     : CLK  clock, rising edge
//             RST  asynchronous, active-low reset
//             bus  jam_solver_if.slave (START, W, J, Cost, BUSY, Valid,
//                  MinCost, MatchCount, BestPerm)
// Params    : N  (2..8) workers = jobs, CW cost entry width
// Macro     : JAM_BEST_PERM_EN - track and expose the first optimal
//             permutation on BestPerm
// Revision  : 1.0 - initial release
// ============================================================================
module jam_solver
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 7
) (
  input  logic       CLK,
  input  logic       RST,
  jam_solver_if.slave bus
);

  localparam int IW  = $clog2(N);
  localparam int SW  = CW + $clog2(N);
  localparam int MW  = cnt_w(N);
  localparam int LCW = $clog2(N * N + 1);

  localparam logic [1:0] c_S_IDLE = IDLE;
  localparam logic [1:0] c_S_LOAD = LOAD;
  localparam logic [1:0] c_S_CALC = CALC;
  localparam logic [1:0] c_S_DONE = DONE;

  localparam logic [LCW-1:0] c_LOAD_LAST = LCW'(N * N);
  localparam logic [IW-1:0]  c_IDX_LAST  = IW'(N - 1);

  typedef logic [N-1:0][IW-1:0] perm_l_t;

  function automatic perm_l_t ident_perm();
    for (int k = 0; k < N; k++) begin
      ident_perm[k] = IW'(k);
    end
  endfunction

  localparam perm_l_t c_IDENT = ident_perm();

  logic [1:0]     r_state;
  logic [IW-1:0]  r_w;
  logic [IW-1:0]  r_j;
  logic [IW-1:0]  r_pw;
  logic [IW-1:0]  r_pj;
  logic [LCW-1:0] r_cnt;
  logic           r_valid;
  logic [SW-1:0]  r_min;
  logic [MW-1:0]  r_match;
  perm_l_t        r_order;
  logic [CW-1:0]  r_tab [N][N];

  perm_l_t        w_next;
  logic           w_last;
  logic [SW-1:0]  w_sum;
  logic           w_calc;
  logic           w_better;
  logic           w_tie;
  logic           w_capture;

  jam_next_perm #(.N(N)) u_next_perm (
    .i_order      (r_order),
    .o_next_order (w_next),
    .o_is_last    (w_last)
  );

  // Total cost of the current assignment. Width SW cannot overflow:
  // N * (2^CW - 1) < 2^(CW + clog2(N)).
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = w_sum + SW'(r_tab[k][r_order[k]]);
    end
  end

  assign w_calc   = (r_state == c_S_CALC);
  assign w_better = (w_sum < r_min);
  assign w_tie    = (w_sum == r_min);
  // Cost arrives one cycle after its address; cycle 0 of LOAD has nothing
  // to capture yet, and the final cycle captures the last address.
  assign w_capture = (r_state == c_S_LOAD) && (r_cnt != '0);

  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_tab[r_pw][r_pj] <= bus.Cost;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_S_IDLE;
      r_w     <= '0;
      r_j     <= '0;
      r_pw    <= '0;
      r_pj    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_min   <= '1;
      r_match <= '0;
      r_order <= c_IDENT;
    end else begin
      case (r_state)
        c_S_IDLE, c_S_DONE: begin
          if (bus.START) begin
            r_state <= c_S_LOAD;
            r_w     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_min   <= '1;
            r_match <= '0;
            r_order <= c_IDENT;
          end
        end
        c_S_LOAD: begin
          r_pw <= r_w;
          r_pj <= r_j;
          if (r_cnt == c_LOAD_LAST) begin
            r_state <= c_S_CALC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // W is the inner index; after the last address both wrap to 0.
            if (r_w == c_IDX_LAST) begin
              r_w <= '0;
              r_j <= (r_j == c_IDX_LAST) ? '0 : r_j + 1'b1;
            end else begin
              r_w <= r_w + 1'b1;
            end
          end
        end
        c_S_CALC: begin
          if (w_better) begin
            r_min   <= w_sum;
            r_match <= MW'(1);
          end else if (w_tie) begin
            r_match <= r_match + 1'b1;
          end
          if (w_last) begin
            r_state <= c_S_DONE;
            r_valid <= 1'b1;
            r_order <= c_IDENT;
          end else begin
            r_order <= w_next;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign bus.W          = r_w;
  assign bus.J          = r_j;
  assign bus.BUSY       = (r_state == c_S_LOAD) || (r_state == c_S_CALC);
  assign bus.Valid      = r_valid;
  assign bus.MinCost    = r_min;
  assign bus.MatchCount = r_match;

`ifdef JAM_BEST_PERM_EN
  // Strict-less update keeps the lexicographically first optimum.
  perm_l_t r_best;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_best <= c_IDENT;
    end else if (w_calc && w_better) begin
      r_best <= r_order;
    end
  end

  assign bus.BestPerm = r_best;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jam_solver.sv
`default_nettype none
// ============================================================================
// Module    : tb_jam_solver
// Purpose   : Self-checking bench for jam_solver: N=3 and N=4 instances run a
//             table of directed cost patterns, two N=8 instances run the
//             full 8! enumeration side by side, plus reset and restart
//             sequences.
// Macro     : JAM_BEST_PERM_EN enables the BestPerm comparisons
// Revision  : 1.0 - initial release
// ============================================================================
module tb_jam_solver;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  jam_solver_if #(.N(3), .CW(7)) bus3  ();
  jam_solver_if #(.N(4), .CW(7)) bus4  ();
  jam_solver_if #(.N(8), .CW(7)) bus8a ();
  jam_solver_if #(.N(8), .CW(7)) bus8b ();

  jam_solver #(.N(3), .CW(7)) dut3  (.CLK(CLK), .RST(RST), .bus(bus3));
  jam_solver #(.N(4), .CW(7)) dut4  (.CLK(CLK), .RST(RST), .bus(bus4));
  jam_solver #(.N(8), .CW(7)) dut8a (.CLK(CLK), .RST(RST), .bus(bus8a));
  jam_solver #(.N(8), .CW(7)) dut8b (.CLK(CLK), .RST(RST), .bus(bus8b));

  // Cost-table ROMs: one-cycle read latency.
  logic [6:0] tab3 [3][3];
  logic [6:0] tab4 [4][4];
  always @(posedge CLK) bus3.Cost <= tab3[bus3.W][bus3.J];
  always @(posedge CLK) bus4.Cost <= tab4[bus4.W][bus4.J];
  assign bus8a.Cost = 7'd127;
  assign bus8b.Cost = 7'd0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n;
    int pat;
    bit poke;
    int exp_min;
    int exp_cnt;
    int exp_lat;
    int exp_best;
  } vec_t;

  vec_t vecs [7];

  function automatic int cost_of(input int pat, input int w, input int j);
    case (pat)
      0: return (j == (w + 1) % 3) ? 1 : 5;
      1: return (w == j) ? 0 : 10;
      2: return 3;
      3: return (w == j) ? 5 : 1;
      4: return 127;
      5: return (w + j == 3) ? 0 : 20;
      6: return (w + j == 2) ? 0 : 4;
      default: return 0;
    endcase
  endfunction

  task automatic set_start(input int n, input logic v);
    if (n == 3) bus3.START = v;
    else        bus4.START = v;
  endtask

  function automatic logic [31:0] rd_valid(input int n);
    return (n == 3) ? 32'(bus3.Valid) : 32'(bus4.Valid);
  endfunction
  function automatic logic [31:0] rd_busy(input int n);
    return (n == 3) ? 32'(bus3.BUSY) : 32'(bus4.BUSY);
  endfunction
  function automatic logic [31:0] rd_min(input int n);
    return (n == 3) ? 32'(bus3.MinCost) : 32'(bus4.MinCost);
  endfunction
  function automatic logic [31:0] rd_cnt(input int n);
    return (n == 3) ? 32'(bus3.MatchCount) : 32'(bus4.MatchCount);
  endfunction
`ifdef JAM_BEST_PERM_EN
  function automatic logic [31:0] rd_best(input int n);
    return (n == 3) ? 32'(bus3.BestPerm) : 32'(bus4.BestPerm);
  endfunction
`endif

  task automatic run_vec(input vec_t v, input int i);
    int lat;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        if (v.n == 3 && w < 3 && j < 3) tab3[w][j] = 7'(cost_of(v.pat, w, j));
        if (v.n == 4) tab4[w][j] = 7'(cost_of(v.pat, w, j));
      end
    end
    @(posedge CLK); #1;
    set_start(v.n, 1'b1);
    @(posedge CLK); #1;
    set_start(v.n, 1'b0);
    lat = 1;
    check($sformatf("v%0d valid_drop", i), rd_valid(v.n), 0);
    check($sformatf("v%0d busy_rise", i), rd_busy(v.n), 1);
    while (rd_valid(v.n) == 0 && lat < 200) begin
      if (v.poke && (lat == 5 || lat == 30)) set_start(v.n, 1'b1);
      else set_start(v.n, 1'b0);
      @(posedge CLK); #1;
      lat++;
    end
    set_start(v.n, 1'b0);
    check($sformatf("v%0d latency", i), lat, v.exp_lat);
    check($sformatf("v%0d min", i), rd_min(v.n), v.exp_min);
    check($sformatf("v%0d count", i), rd_cnt(v.n), v.exp_cnt);
    check($sformatf("v%0d busy_done", i), rd_busy(v.n), 0);
`ifdef JAM_BEST_PERM_EN
    check($sformatf("v%0d best", i), rd_best(v.n), v.exp_best);
`endif
    @(posedge CLK); #1;
    check($sformatf("v%0d valid_hold", i), rd_valid(v.n), 1);
    check($sformatf("v%0d min_hold", i), rd_min(v.n), v.exp_min);
  endtask

  initial begin
    int lat;
    logic [23:0] ident8;
    ident8 = '0;
    for (int k = 0; k < 8; k++) ident8 = ident8 | (24'(k) << (3 * k));

    //          n  pat poke min  cnt lat  best
    vecs[0] = '{3, 0, 1'b0,   3,  1, 17, 'h09};
    vecs[1] = '{3, 3, 1'b0,   3,  2, 17, 'h09};
    vecs[2] = '{3, 6, 1'b0,   0,  1, 17, 'h06};
    vecs[3] = '{4, 1, 1'b0,   0,  1, 42, 'hE4};
    vecs[4] = '{4, 2, 1'b1,  12, 24, 42, 'hE4};
    vecs[5] = '{4, 5, 1'b0,   0,  1, 42, 'h1B};
    vecs[6] = '{4, 4, 1'b0, 508, 24, 42, 'hE4};

    RST = 1'b0;
    bus3.START = 1'b0; bus4.START = 1'b0; bus8a.START = 1'b0; bus8b.START = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++) begin
        tab4[w][j] = '0;
        if (w < 3 && j < 3) tab3[w][j] = '0;
      end

    repeat (3) @(posedge CLK);
    #1;
    check("rst W", 32'(bus4.W), 0);
    check("rst J", 32'(bus4.J), 0);
    check("rst BUSY", 32'(bus4.BUSY), 0);
    check("rst Valid", 32'(bus4.Valid), 0);
    check("rst MinCost4", 32'(bus4.MinCost), 511);
    check("rst MatchCount4", 32'(bus4.MatchCount), 0);
    check("rst MinCost8", 32'(bus8a.MinCost), 1023);
`ifdef JAM_BEST_PERM_EN
    check("rst BestPerm4", 32'(bus4.BestPerm), 'hE4);
    check("rst BestPerm8", 32'(bus8a.BestPerm), 32'(ident8));
`endif
    RST = 1'b1;
    @(posedge CLK); #1;

    // Reset during CALC cycle 30 of an N=8 run (CALC begins after edge 66).
    bus8a.START = 1'b1;
    @(posedge CLK); #1;
    bus8a.START = 1'b0;
    lat = 1;
    while (lat < 95) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("mid BUSY", 32'(bus8a.BUSY), 1);
    check("mid MinCost", 32'(bus8a.MinCost), 1016);
    check("mid MatchCount", 32'(bus8a.MatchCount), 29);
    RST = 1'b0;
    #1;
    check("async MinCost", 32'(bus8a.MinCost), 1023);
    @(posedge CLK); #1;
    check("mrst W", 32'(bus8a.W), 0);
    check("mrst J", 32'(bus8a.J), 0);
    check("mrst BUSY", 32'(bus8a.BUSY), 0);
    check("mrst Valid", 32'(bus8a.Valid), 0);
    check("mrst MinCost", 32'(bus8a.MinCost), 1023);
    check("mrst MatchCount", 32'(bus8a.MatchCount), 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Full N=8 runs, all 127 and all 0, side by side.
    bus8a.START = 1'b1;
    bus8b.START = 1'b1;
    @(posedge CLK); #1;
    bus8a.START = 1'b0;
    bus8b.START = 1'b0;
    lat = 1;
    while (!bus8a.Valid && lat < 41000) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("n8 latency", lat, 40386);
    check("n8 b Valid", 32'(bus8b.Valid), 1);
    check("n8 a MinCost", 32'(bus8a.MinCost), 1016);
    check("n8 a MatchCount", 32'(bus8a.MatchCount), 40320);
    check("n8 b MinCost", 32'(bus8b.MinCost), 0);
    check("n8 b MatchCount", 32'(bus8b.MatchCount), 40320);
    check("n8 a BUSY", 32'(bus8a.BUSY), 0);
`ifdef JAM_BEST_PERM_EN
    check("n8 a BestPerm", 32'(bus8a.BestPerm), 32'(ident8));
    check("n8 b BestPerm", 32'(bus8b.BestPerm), 32'(ident8));
`endif

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
